// File: rtl/fp16_mul_result_fifo_if.sv
// fp16_mul_result_fifo_if: handshake bundle between the fp16 multiplier,
// the result FIFO and the consumer datapath.
// master: producer/consumer side (testbench or surrounding datapath).
// slave : the FIFO itself.
interface fp16_mul_result_fifo_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_mul_ok;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_class;

  modport master (
    output in_valid, in_data, in_mul_ok, out_ready,
    input  in_ready, out_valid, out_data, out_class
  );

  modport slave (
    input  in_valid, in_data, in_mul_ok, out_ready,
    output in_ready, out_valid, out_data, out_class
  );
endinterface

// File: rtl/fp16_mul_result_fifo.sv
// fp16_mul_result_fifo: first-word-fall-through FIFO behind the fp16
// multiplier. Each entry carries the product word and its half-precision
// class {nan, inf, sub, zero}; saturating exception counters and sticky
// flags are kept for the consumer.
// Optional feature macro: FP16_CANON_NAN_EN -- when defined, NaN entries
// are stored as the canonical quiet NaN 16'h7E00 instead of the raw word.
module fp16_mul_result_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fp16_mul_result_fifo_if.slave bus,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     nan_cnt,
  output logic [CNT_W-1:0]     inf_cnt,
  output logic [CNT_W-1:0]     zero_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [4:0]           sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {LVL_EMPTY, LVL_PARTIAL, LVL_FULL} level_e;

  level_e            level_q, level_d;
  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]       data_mem_q [DEPTH];
  logic [15:0]       data_mem_d [DEPTH];
  logic [3:0]        class_mem_q [DEPTH];
  logic [3:0]        class_mem_d [DEPTH];
  logic [15:0]       last_data_q, last_data_d;
  logic [3:0]        last_class_q, last_class_d;
  logic [CNT_W-1:0]  nan_cnt_q, nan_cnt_d, inf_cnt_q, inf_cnt_d;
  logic [CNT_W-1:0]  zero_cnt_q, zero_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [4:0]        sticky_q, sticky_d;

  logic [4:0]  in_exp;
  logic [9:0]  in_frac;
  logic        is_nan, is_inf, is_sub, is_zero;
  logic [3:0]  in_class;
  logic [15:0] store_data;
  logic        wr_en, rd_en, drop_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Handshake flags come straight from the registered level, never from inputs
  assign bus.in_ready  = (level_q != LVL_FULL);
  assign bus.out_valid = (level_q != LVL_EMPTY);
  assign wr_en         = bus.in_valid & bus.in_ready;
  assign rd_en         = bus.out_valid & bus.out_ready;
  assign drop_evt      = bus.in_valid & ~bus.in_ready;

  // Classify the incoming product; NaN masks every other class bit
  always_comb begin
    in_exp     = bus.in_data[14:10];
    in_frac    = bus.in_data[9:0];
    is_nan     = ~bus.in_mul_ok | ((in_exp == 5'h1F) & (in_frac != 10'd0));
    is_inf     = ~is_nan & (in_exp == 5'h1F) & (in_frac == 10'd0);
    is_zero    = ~is_nan & (in_exp == 5'h00) & (in_frac == 10'd0);
    is_sub     = ~is_nan & (in_exp == 5'h00) & (in_frac != 10'd0);
    in_class   = {is_nan, is_inf, is_sub, is_zero};
`ifdef FP16_CANON_NAN_EN
    store_data = is_nan ? 16'h7E00 : bus.in_data;
`else
    store_data = bus.in_data;
`endif
  end

  // Level FSM: occupancy count and EMPTY/PARTIAL/FULL tracking
  always_comb begin
    level_d = level_q;
    count_d = count_q;
    case (level_q)
      LVL_EMPTY: begin
        if (wr_en) begin
          count_d = (AW+1)'(1);
          level_d = LVL_PARTIAL;
        end
      end
      LVL_PARTIAL: begin
        if (wr_en && !rd_en) begin
          count_d = count_q + 1'b1;
          if (count_d == FULL_CNT) level_d = LVL_FULL;
        end else if (rd_en && !wr_en) begin
          count_d = count_q - 1'b1;
          if (count_d == '0) level_d = LVL_EMPTY;
        end
      end
      LVL_FULL: begin
        if (rd_en) begin
          count_d = count_q - 1'b1;
          level_d = LVL_PARTIAL;
        end
      end
      default: begin
        level_d = LVL_EMPTY;
        count_d = '0;
      end
    endcase
  end

  // Storage, pointers and the last-popped holding register
  always_comb begin
    data_mem_d   = data_mem_q;
    class_mem_d  = class_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    last_data_d  = last_data_q;
    last_class_d = last_class_q;
    if (wr_en) begin
      data_mem_d[wr_ptr_q]  = store_data;
      class_mem_d[wr_ptr_q] = in_class;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      last_data_d  = data_mem_q[rd_ptr_q];
      last_class_d = class_mem_q[rd_ptr_q];
      rd_ptr_d     = rd_ptr_q + 1'b1;
    end
  end

  // Head is shown while occupied; when empty the last popped entry is held
  assign bus.out_data  = (level_q == LVL_EMPTY) ? last_data_q  : data_mem_q[rd_ptr_q];
  assign bus.out_class = (level_q == LVL_EMPTY) ? last_class_q : class_mem_q[rd_ptr_q];

  // Statistics: clear wins over any event in the same cycle
  always_comb begin
    nan_cnt_d  = nan_cnt_q;
    inf_cnt_d  = inf_cnt_q;
    zero_cnt_d = zero_cnt_q;
    drop_cnt_d = drop_cnt_q;
    sticky_d   = sticky_q;
    if (clr_stats) begin
      nan_cnt_d  = '0;
      inf_cnt_d  = '0;
      zero_cnt_d = '0;
      drop_cnt_d = '0;
      sticky_d   = '0;
    end else begin
      if (wr_en) begin
        if (is_nan)  nan_cnt_d  = sat_inc(nan_cnt_q);
        if (is_inf)  inf_cnt_d  = sat_inc(inf_cnt_q);
        if (is_zero) zero_cnt_d = sat_inc(zero_cnt_q);
        sticky_d[3:0] = sticky_q[3:0] | in_class;
      end
      if (drop_evt) begin
        drop_cnt_d  = sat_inc(drop_cnt_q);
        sticky_d[4] = 1'b1;
      end
    end
  end

  assign nan_cnt  = nan_cnt_q;
  assign inf_cnt  = inf_cnt_q;
  assign zero_cnt = zero_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign sticky   = sticky_q;

  // State register; reset discards all queued entries immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q      <= LVL_EMPTY;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_data_q  <= '0;
      last_class_q <= '0;
      nan_cnt_q    <= '0;
      inf_cnt_q    <= '0;
      zero_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      sticky_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i]  <= '0;
        class_mem_q[i] <= '0;
      end
    end else begin
      level_q      <= level_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_data_q  <= last_data_d;
      last_class_q <= last_class_d;
      nan_cnt_q    <= nan_cnt_d;
      inf_cnt_q    <= inf_cnt_d;
      zero_cnt_q   <= zero_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      sticky_q     <= sticky_d;
      data_mem_q   <= data_mem_d;
      class_mem_q  <= class_mem_d;
    end
  end

endmodule

// File: tb/tb_fp16_mul_result_fifo.sv
// tb_fp16_mul_result_fifo: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the result FIFO.
module tb_fp16_mul_result_fifo;
  localparam int DEPTH = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_stats = 1'b0;
  logic [CNT_W-1:0] nan_cnt, inf_cnt, zero_cnt, drop_cnt;
  logic [4:0] sticky;

  fp16_mul_result_fifo_if bus ();

  fp16_mul_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clr_stats(clr_stats),
    .nan_cnt(nan_cnt), .inf_cnt(inf_cnt), .zero_cnt(zero_cnt),
    .drop_cnt(drop_cnt), .sticky(sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  c;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_last_d;
  logic [3:0]  m_last_c;
  int          m_nan, m_inf, m_zero, m_drop;
  logic [4:0]  m_sticky;
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic logic [3:0] ref_class(input logic [15:0] w, input logic ok);
    int e, f;
    e = int'(w[14:10]);
    f = int'(w[9:0]);
    if (!ok || (e == 31 && f != 0)) return 4'b1000;
    if (e == 31) return 4'b0100;
    if (e == 0 && f == 0) return 4'b0001;
    if (e == 0) return 4'b0010;
    return 4'b0000;
  endfunction

  function automatic logic [15:0] ref_store(input logic [15:0] w, input logic ok);
`ifdef FP16_CANON_NAN_EN
    if (ref_class(w, ok) == 4'b1000) return 16'h7E00;
`endif
    return w;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last_d = '0; m_last_c = '0;
    m_nan = 0; m_inf = 0; m_zero = 0; m_drop = 0;
    m_sticky = '0;
  endtask

  task automatic set_idle();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mul_ok = 1'b1;
    bus.out_ready = 1'b0; clr_stats = 1'b0;
  endtask

  // Advance one clock: update the model from current inputs, then step the DUT.
  task automatic tick();
    bit wr, rd, drop;
    logic [3:0] cls;
    ent_t e;
    wr   = bus.in_valid && (mq.size() < DEPTH);
    drop = bus.in_valid && (mq.size() >= DEPTH);
    rd   = bus.out_ready && (mq.size() > 0);
    cls  = ref_class(bus.in_data, bus.in_mul_ok);
    if (clr_stats) begin
      m_nan = 0; m_inf = 0; m_zero = 0; m_drop = 0; m_sticky = '0;
    end else begin
      if (wr) begin
        if (cls[3]) m_nan  = sat(m_nan + 1);
        if (cls[2]) m_inf  = sat(m_inf + 1);
        if (cls[0]) m_zero = sat(m_zero + 1);
        m_sticky[3:0] |= cls;
      end
      if (drop) begin
        m_drop = sat(m_drop + 1);
        m_sticky[4] = 1'b1;
      end
    end
    if (rd) begin
      e = mq.pop_front();
      m_last_d = e.d; m_last_c = e.c;
    end
    if (wr) begin
      e.d = ref_store(bus.in_data, bus.in_mul_ok);
      e.c = cls;
      mq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1; #3; model_reset(); rst = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_vec++; if (bus.out_data !== 16'h0 || bus.out_class !== 4'h0) begin n_miss++; $display("[TB] FAIL reset_head got %h/%b want 0000/0000", bus.out_data, bus.out_class); end
    // mid-stream reset with queued entries and stats activity
    bus.in_mul_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'($urandom); tick();
    end
    bus.in_valid = 1'b0; bus.in_mul_ok = 1'b1;
    n_vec++; if (bus.out_valid !== 1'b1 || nan_cnt !== CNT_W'(3)) begin n_miss++; $display("[TB] FAIL prereset_state got ov=%b nan=%0d want ov=1 nan=3", bus.out_valid, nan_cnt); end
    rst = 1'b1; #2; model_reset();
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL midreset_flags got ov=%b ir=%b want 0/1", bus.out_valid, bus.in_ready); end
    n_vec++; if (nan_cnt !== '0 || inf_cnt !== '0 || zero_cnt !== '0 || drop_cnt !== '0 || sticky !== 5'b0) begin n_miss++; $display("[TB] FAIL midreset_stats got %0d %0d %0d %0d %b want all 0", nan_cnt, inf_cnt, zero_cnt, drop_cnt, sticky); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_class();
    logic [15:0] words [5];
    logic        oks [5];
    logic [3:0]  want_c [5];
    words = '{16'h3C00, 16'h0000, 16'h0001, 16'h7C00, 16'h1234};
    oks   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    want_c = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    set_idle();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = words[i]; bus.in_mul_ok = oks[i]; tick();
    end
    set_idle();
    n_vec++; if (zero_cnt !== CNT_W'(1) || inf_cnt !== CNT_W'(1) || nan_cnt !== CNT_W'(1)) begin n_miss++; $display("[TB] FAIL class_counts got z=%0d i=%0d n=%0d want 1 1 1", zero_cnt, inf_cnt, nan_cnt); end
    n_vec++; if (sticky !== 5'b01111) begin n_miss++; $display("[TB] FAIL class_sticky got %b want 01111", sticky); end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_class !== want_c[i] || bus.out_data !== ref_store(words[i], oks[i])) begin
        n_miss++; $display("[TB] FAIL class_entry%0d got v=%b %h/%b want 1 %h/%b", i, bus.out_valid, bus.out_data, bus.out_class, ref_store(words[i], oks[i]), want_c[i]);
      end
      bus.out_ready = 1'b1; tick();
    end
    set_idle();
    n_vec++; if (bus.out_valid !== 1'b0 || bus.out_class !== 4'b1000 || bus.out_data !== m_last_d) begin n_miss++; $display("[TB] FAIL class_hold got v=%b %h/%b want 0 %h/1000", bus.out_valid, bus.out_data, bus.out_class, m_last_d); end
  endtask

  task automatic test_full();
    logic [15:0] want;
    set_idle();
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'($urandom); tick();
      if (i == 6) begin
        n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL full_ready7 got %b want 1", bus.in_ready); end
      end
      if (i == 7) begin
        n_vec++; if (bus.in_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL full_ready8 got %b want 0", bus.in_ready); end
      end
    end
    set_idle();
    n_vec++; if (drop_cnt !== CNT_W'(2) || sticky[4] !== 1'b1) begin n_miss++; $display("[TB] FAIL full_drop got cnt=%0d st=%b want 2/1", drop_cnt, sticky[4]); end
    for (int i = 0; i < DEPTH; i++) begin
      want = mq[0].d;
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== want) begin n_miss++; $display("[TB] FAIL full_drain%0d got v=%b %h want 1 %h", i, bus.out_valid, bus.out_data, want); end
      bus.out_ready = 1'b1; tick();
      if (i == 0) begin
        n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL full_ready_after_read got %b want 1", bus.in_ready); end
      end
    end
    set_idle();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL full_empty got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'h4000 + 16'(i); tick();
    end
    bus.in_data = 16'h4100; bus.out_ready = 1'b1; tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== mq[0].d) begin n_miss++; $display("[TB] FAIL simul_drain%0d got v=%b %h want 1 %h", i, bus.out_valid, bus.out_data, mq[0].d); end
      bus.out_ready = 1'b1; tick();
    end
    set_idle();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL simul_count3 got v=%b want 0", bus.out_valid); end
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'($urandom); tick();
    end
    bus.in_data = 16'hABCD; bus.out_ready = 1'b1; tick();
    set_idle();
    n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL simul_full_ready got %b want 1", bus.in_ready); end
    for (int i = 0; i < DEPTH - 1; i++) begin
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== mq[0].d) begin n_miss++; $display("[TB] FAIL simul_full_drain%0d got v=%b %h want 1 %h", i, bus.out_valid, bus.out_data, mq[0].d); end
      bus.out_ready = 1'b1; tick();
    end
    set_idle();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL simul_count7 got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_sat_clear();
    set_idle();
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_mul_ok = 1'b0; bus.in_data = 16'($urandom); bus.out_ready = 1'b1; tick();
    end
    n_vec++; if (nan_cnt !== CNT_W'(3)) begin n_miss++; $display("[TB] FAIL sat_nan got %0d want 3", nan_cnt); end
    bus.out_ready = 1'b0; clr_stats = 1'b1; bus.in_data = 16'h7E55; tick();
    set_idle();
    n_vec++; if (nan_cnt !== '0 || sticky !== 5'b0) begin n_miss++; $display("[TB] FAIL clr_priority got nan=%0d st=%b want 0/00000", nan_cnt, sticky); end
    while (mq.size() > 0) begin
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== mq[0].d || bus.out_class !== 4'b1000) begin n_miss++; $display("[TB] FAIL clr_queued got v=%b %h/%b want 1 %h/1000", bus.out_valid, bus.out_data, bus.out_class, mq[0].d); end
      bus.out_ready = 1'b1; tick();
    end
    set_idle();
  endtask

  task automatic test_macro();
    logic [15:0] want;
`ifdef FP16_CANON_NAN_EN
    want = 16'h7E00;
`else
    want = 16'hFE01;
`endif
    set_idle();
    bus.in_valid = 1'b1; bus.in_data = 16'hFE01; tick();
    set_idle();
    n_vec++; if (bus.out_data !== want || bus.out_class !== 4'b1000) begin n_miss++; $display("[TB] FAIL macro_nan got %h/%b want %h/1000", bus.out_data, bus.out_class, want); end
    bus.out_ready = 1'b1; tick();
    set_idle();
  endtask

  task automatic test_random();
    logic [15:0] wd;
    logic [3:0]  wc;
    set_idle();
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_mul_ok = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 4))
        0: bus.in_data = {1'($urandom), 5'h1F, 10'($urandom_range(0, 1))};
        1: bus.in_data = {1'($urandom), 5'h00, 10'($urandom_range(0, 1))};
        default: bus.in_data = 16'($urandom);
      endcase
      bus.out_ready = ($urandom_range(0, 2) == 0) || (n > 350);
      clr_stats = ($urandom_range(0, 29) == 0);
      wd = (mq.size() > 0) ? mq[0].d : m_last_d;
      wc = (mq.size() > 0) ? mq[0].c : m_last_c;
      n_vec++; if (bus.in_ready !== (mq.size() < DEPTH) || bus.out_valid !== (mq.size() > 0)) begin n_miss++; $display("[TB] FAIL rnd_flags@%0d got ir=%b ov=%b want %b %b", n, bus.in_ready, bus.out_valid, mq.size() < DEPTH, mq.size() > 0); end
      n_vec++; if (bus.out_data !== wd || bus.out_class !== wc) begin n_miss++; $display("[TB] FAIL rnd_head@%0d got %h/%b want %h/%b", n, bus.out_data, bus.out_class, wd, wc); end
      n_vec++; if (nan_cnt !== CNT_W'(m_nan) || inf_cnt !== CNT_W'(m_inf) || zero_cnt !== CNT_W'(m_zero) || drop_cnt !== CNT_W'(m_drop)) begin n_miss++; $display("[TB] FAIL rnd_cnt@%0d got %0d %0d %0d %0d want %0d %0d %0d %0d", n, nan_cnt, inf_cnt, zero_cnt, drop_cnt, m_nan, m_inf, m_zero, m_drop); end
      n_vec++; if (sticky !== m_sticky) begin n_miss++; $display("[TB] FAIL rnd_sticky@%0d got %b want %b", n, sticky, m_sticky); end
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_class();
    test_full();
    test_back_to_back();
    test_sat_clear();
    test_macro();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
